// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, holds the
// returned word until the instruction buffer accepts it, and handles redirects.
module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  input  logic [XLEN-1:0] branch_target,
  input  logic            ib_full,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_npc,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_npc_q, hold_npc_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      drop_q      <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      hold_npc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_npc_q  <= hold_npc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    drop_d        = drop_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    hold_npc_d    = hold_npc_q;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_valid = !squash;
        if (squash) begin
          pc_d = branch_target;
        end else if (mem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // drop marks the outstanding response as stale after a redirect
        if (squash) begin
          pc_d = branch_target;
          if (mem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end else if (mem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            hold_inst_d = mem_resp_data;
            hold_pc_d   = req_pc_q;
            hold_npc_d  = req_pc_q + INST_BYTES;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        out_valid = !squash;
        if (squash) begin
          pc_d    = branch_target;
          state_d = S_FETCH;
        end else if (!ib_full) begin
          pc_d    = req_pc_q + INST_BYTES;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
    end
  end

  assign mem_req_addr = pc_q;
  assign out_inst     = hold_inst_q;
  assign out_pc       = hold_pc_q;
  assign out_npc      = hold_npc_q;
  assign busy         = !reset && (state_q != S_FETCH);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable memory model
// plus request and packet scoreboards popped as the DUT produces them.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } pkt_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic [31:0] branch_target = '0;
  logic        ib_full = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int req_count = 0;
  int push_count = 0;
  int valid_cycles = 0;
  int mem_lat = 2;
  int resp_cnt = 0;
  logic [31:0] resp_word = '0;
  bit          fixed_data = 1'b1;
  logic [31:0] fixed_word = 32'h0000_0013;

  logic [31:0] exp_req_q[$];
  pkt_t        exp_push_q[$];

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .squash(squash), .branch_target(branch_target),
    .ib_full(ib_full), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_npc(out_npc), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_for(input logic [31:0] addr);
    return fixed_data ? fixed_word : (addr ^ 32'hA5A5_0000);
  endfunction

  // Memory model drives responses at the falling edge; monitor samples 3ns later
  always @(negedge clock) begin
    pkt_t e;
    logic [31:0] ea;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'hBAD0_BAD0;
    if (resp_cnt == 1) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = resp_word;
    end
    if (resp_cnt > 0) resp_cnt--;
    #3;
    if (mem_req_valid && mem_req_ready) begin
      req_count++;
      resp_cnt  = mem_lat;
      resp_word = word_for(mem_req_addr);
      vectors++;
      if (exp_req_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_request addr=%h", mem_req_addr);
      end else begin
        ea = exp_req_q.pop_front();
        if (mem_req_addr !== ea) begin
          miscompares++;
          $display("[TB] FAIL req_addr got=%h exp=%h", mem_req_addr, ea);
        end
      end
    end
    if (out_valid === 1'b1) valid_cycles++;
    if (out_valid === 1'b1 && !ib_full) begin
      push_count++;
      vectors++;
      if (exp_push_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_push pc=%h inst=%h", out_pc, out_inst);
      end else begin
        e = exp_push_q.pop_front();
        if (out_inst !== e.inst || out_pc !== e.pc || out_npc !== e.npc) begin
          miscompares++;
          $display("[TB] FAIL push got inst=%h pc=%h npc=%h exp inst=%h pc=%h npc=%h",
                   out_inst, out_pc, out_npc, e.inst, e.pc, e.npc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_req(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_count >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_push(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (push_count >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_resp_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, output bit ok);
    bit ok_req, ok_push;
    int rc, pc;
    rc = req_count;
    pc = push_count;
    exp_req_q.push_back(addr);
    exp_push_q.push_back('{word_for(addr), addr, addr + 32'd4});
    mem_req_ready = 1'b1;
    wait_req(rc + 1, ok_req);
    mem_req_ready = 1'b0;
    wait_push(pc + 1, ok_push);
    ok = ok_req && ok_push;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    #1;
    vectors++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got req_valid=%b out_valid=%b busy=%b exp 0 0 0",
               mem_req_valid, out_valid, busy);
    end
    vectors++;
    if (out_inst !== 32'h0 || out_pc !== 32'h0 || out_npc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got inst=%h pc=%h npc=%h exp 0", out_inst, out_pc, out_npc);
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      miscompares++;
      $display("[TB] FAIL first_req got valid=%b addr=%h exp 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    fixed_data = 1'b1;
    fixed_word = 32'h0000_0013;
    mem_lat = 2;
    do_fetch(RESET_PC, ok);
    #1;
    vectors++;
    if (!ok || mem_req_addr !== 32'h0 || mem_req_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap ok=%b next_addr=%h valid=%b exp 1 00000000 1", ok, mem_req_addr, mem_req_valid);
    end
  endtask

  task automatic test_sequential();
    bit ok_req, ok_push;
    int rc, pc, vc;
    rc = req_count; pc = push_count; vc = valid_cycles;
    for (int i = 0; i < 3; i++) begin
      exp_req_q.push_back(32'(i * 4));
      exp_push_q.push_back('{32'h0000_0013, 32'(i * 4), 32'(i * 4 + 4)});
    end
    mem_req_ready = 1'b1;
    wait_req(rc + 3, ok_req);
    mem_req_ready = 1'b0;
    wait_push(pc + 3, ok_push);
    vectors++;
    if (!ok_req || !ok_push || (valid_cycles - vc) != 3) begin
      miscompares++;
      $display("[TB] FAIL sequential ok=%b%b valid_cycles=%0d exp 3", ok_req, ok_push, valid_cycles - vc);
    end
    vectors++;
    if (exp_push_q.size() != 0 || exp_req_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sequential_drain left pushes=%0d reqs=%0d exp 0", exp_push_q.size(), exp_req_q.size());
    end
  endtask

  task automatic test_ib_full();
    bit ok;
    int pc;
    squash = 1'b1;
    branch_target = 32'h10;
    #1;
    vectors++;
    if (mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL squash_fetch req_valid=%b exp 0", mem_req_valid);
    end
    tick();
    squash = 1'b0;
    #1;
    vectors++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10) begin
      miscompares++;
      $display("[TB] FAIL squash_fetch_addr got %b %h exp 1 00000010", mem_req_valid, mem_req_addr);
    end
    fixed_data = 1'b0;
    ib_full = 1'b1;
    pc = push_count;
    exp_req_q.push_back(32'h10);
    exp_push_q.push_back('{word_for(32'h10), 32'h10, 32'h14});
    mem_req_ready = 1'b1;
    wait_req(req_count + 1, ok);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 || mem_req_valid !== 1'b0 ||
          out_inst !== word_for(32'h10)) begin
        miscompares++;
        $display("[TB] FAIL ib_full_hold cyc=%0d valid=%b pc=%h inst=%h req=%b exp 1 00000010 %h 0",
                 i, out_valid, out_pc, out_inst, mem_req_valid, word_for(32'h10));
      end
      tick();
    end
    ib_full = 1'b0;
    wait_push(pc + 1, ok);
    vectors++;
    if (!ok || exp_push_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ib_full_release ok=%b left=%0d exp 1 0", ok, exp_push_q.size());
    end
  endtask

  task automatic test_squash_wait();
    bit ok;
    int pc;
    mem_lat = 4;
    exp_req_q.push_back(32'h14);
    mem_req_ready = 1'b1;
    wait_req(req_count + 1, ok);
    mem_req_ready = 1'b0;
    pc = push_count;
    squash = 1'b1;
    branch_target = 32'hF0;
    tick();
    branch_target = 32'h100;
    #1;
    vectors++;
    if (!ok || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL squash_wait_busy ok=%b busy=%b exp 1 1", ok, busy);
    end
    tick();
    squash = 1'b0;
    wait_resp(ok);
    repeat (4) tick();
    vectors++;
    if (!ok || push_count != pc || mem_req_addr !== 32'h100 || mem_req_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL squash_wait ok=%b pushes=%0d addr=%h exp 1 0 00000100",
               ok, push_count - pc, mem_req_addr);
    end
    mem_lat = 2;
    do_fetch(32'h100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL refetch_100 timeout got 0 exp 1");
    end
  endtask

  task automatic test_squash_resp();
    bit ok, ok2;
    int pc;
    exp_req_q.push_back(32'h104);
    mem_req_ready = 1'b1;
    wait_req(req_count + 1, ok);
    mem_req_ready = 1'b0;
    pc = push_count;
    wait_resp(ok2);
    squash = 1'b1;
    branch_target = 32'h200;
    tick();
    squash = 1'b0;
    #1;
    vectors++;
    if (!ok || !ok2 || busy !== 1'b0 || mem_req_addr !== 32'h200) begin
      miscompares++;
      $display("[TB] FAIL squash_resp ok=%b%b busy=%b addr=%h exp 11 0 00000200", ok, ok2, busy, mem_req_addr);
    end
    repeat (3) tick();
    vectors++;
    if (push_count != pc) begin
      miscompares++;
      $display("[TB] FAIL squash_resp_push pushes=%0d exp 0", push_count - pc);
    end
    do_fetch(32'h200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL refetch_200 timeout got 0 exp 1");
    end
  endtask

  task automatic test_squash_hold();
    bit ok, ok2;
    int pc;
    exp_req_q.push_back(32'h204);
    mem_req_ready = 1'b1;
    wait_req(req_count + 1, ok);
    mem_req_ready = 1'b0;
    pc = push_count;
    wait_resp(ok2);
    tick();
    squash = 1'b1;
    branch_target = 32'h300;
    #1;
    vectors++;
    if (!ok || !ok2 || out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL squash_hold ok=%b%b out_valid=%b busy=%b exp 11 0 1", ok, ok2, out_valid, busy);
    end
    tick();
    squash = 1'b0;
    #1;
    vectors++;
    if (push_count != pc || mem_req_addr !== 32'h300 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL squash_hold_next pushes=%0d addr=%h busy=%b exp 0 00000300 0",
               push_count - pc, mem_req_addr, busy);
    end
    do_fetch(32'h300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL refetch_300 timeout got 0 exp 1");
    end
  endtask

  task automatic test_zero_inst();
    bit ok;
    fixed_data = 1'b1;
    fixed_word = 32'h0;
    do_fetch(32'h304, ok);
    vectors++;
    if (!ok || exp_push_q.size() != 0 || exp_req_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_inst ok=%b left=%0d/%0d exp 1 0/0", ok, exp_push_q.size(), exp_req_q.size());
    end
  endtask

  initial begin
    $display("[TB] starting fetch_unit bench");
    tick();
    test_reset();
    test_wrap();
    test_sequential();
    test_ib_full();
    test_squash_wait();
    test_squash_resp();
    test_squash_hold();
    test_zero_inst();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
